clock_rate_controller: RTL and testbench

Programmable, run/halt/single-step controlled clock-rate generator for the pico processor core. From the 20 MHz board clock it produces a divided square wave and a one-cycle clock-enable pulse at 20 MHz / 2^(SEL+1), covering 10 MHz down to about 0.6 Hz. Rate changes and halts take effect only at period boundaries, so no output pulse is ever truncated. Processor logic runs on IN_CLK and is qualified by CLK_EN; OUT_CLK drives LEDs and the debug header.

---
 rtl/clock_rate_controller.sv | 99 +++++++++
 tb/tb_clock_rate_controller.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_rate_controller.sv
// Run/halt/single-step clock-rate generator: divides in_clk by 2^(cur_sel+1) into out_clk plus a one-cycle clk_en.
// Every output is a flop; rate changes and halts land only on the out_clk 1->0 edge, so no phase is ever truncated.
`timescale 1ns/1ps
module clock_rate_controller #(
  parameter int MAX_SEL   = 24,
  parameter int RESET_SEL = 0,
  parameter int CNT_W     = 24
) (
  input  logic       in_clk,
  input  logic       rst_n,
  input  logic [4:0] sel,
  input  logic       sel_load,
  input  logic       run,
  input  logic       step,
  output logic       out_clk,
  output logic       clk_en,
  output logic [4:0] cur_sel,
  output logic       sel_pend,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_STEP  = 2'd3
  } state_t;

  state_t           st;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] term_val;
  logic [4:0]       pend_sel;
  logic [4:0]       sel_clamped;
  logic             counting;
  logic             term;
  logic             boundary;

  assign sel_clamped = (int'(sel) > MAX_SEL) ? 5'(MAX_SEL) : sel;
  // For cur_sel == CNT_W the shift wraps to zero and the subtract yields all ones.
  assign term_val    = (CNT_W'(1) << cur_sel) - CNT_W'(1);
  assign counting    = (st != ST_HALT);
  assign term        = counting && (cnt == term_val);
  assign boundary    = term && out_clk;
  assign state       = st;

  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= ST_HALT;
      cnt      <= '0;
      out_clk  <= 1'b0;
      clk_en   <= 1'b0;
      cur_sel  <= 5'(RESET_SEL);
      pend_sel <= 5'(RESET_SEL);
      sel_pend <= 1'b0;
    end else begin
      clk_en <= term && !out_clk;

      if (!counting || term) cnt <= '0;
      else                   cnt <= cnt + CNT_W'(1);

      if (!counting)  out_clk <= 1'b0;
      else if (term)  out_clk <= !out_clk;

      // A value left pending by a load on the halting edge is applied once idle.
      if (st == ST_HALT) begin
        sel_pend <= 1'b0;
        if (sel_load)      cur_sel <= sel_clamped;
        else if (sel_pend) cur_sel <= pend_sel;
      end else begin
        if (boundary && sel_pend) cur_sel <= pend_sel;
        if (sel_load) begin
          pend_sel <= sel_clamped;
          sel_pend <= 1'b1;
        end else if (boundary) begin
          sel_pend <= 1'b0;
        end
      end

      case (st)
        ST_HALT: begin
          if (run)       st <= ST_RUN;
          else if (step) st <= ST_STEP;
        end
        ST_RUN: begin
          if (!run) st <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (run)           st <= ST_RUN;
          else if (boundary) st <= ST_HALT;
        end
        ST_STEP: begin
          if (boundary) st <= run ? ST_RUN : ST_HALT;
        end
        default: st <= ST_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_rate_controller.sv
// Directed bench for clock_rate_controller: reset, rates, drain, step, clamp, async reset, load collisions.
`timescale 1ns/1ps
module tb_clock_rate_controller;

  logic       in_clk = 1'b0;
  logic       rst_n;
  logic [4:0] sel;
  logic       sel_load;
  logic       run;
  logic       step;
  logic       out_clk;
  logic       clk_en;
  logic [4:0] cur_sel;
  logic       sel_pend;
  logic [1:0] state;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [1:0] S_HALT = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_STEP = 2'd3;

  clock_rate_controller dut (
    .in_clk  (in_clk),
    .rst_n   (rst_n),
    .sel     (sel),
    .sel_load(sel_load),
    .run     (run),
    .step    (step),
    .out_clk (out_clk),
    .clk_en  (clk_en),
    .cur_sel (cur_sel),
    .sel_pend(sel_pend),
    .state   (state)
  );

  always #5 in_clk = ~in_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic load_sel(input logic [4:0] v);
    sel      = v;
    sel_load = 1'b1;
    tick();
    sel_load = 1'b0;
  endtask

  initial begin
    int  budget;
    rst_n = 1'b0; sel = '0; sel_load = 1'b0; run = 1'b0; step = 1'b0;
    tick(); tick();
    chk("rst_state", state, S_HALT);
    chk("rst_out_clk", out_clk, 0);
    chk("rst_clk_en", clk_en, 0);
    chk("rst_sel_pend", sel_pend, 0);
    chk("rst_cur_sel", cur_sel, 0);
    rst_n = 1'b1;
    tick();

    // 1: default rate, toggles every cycle from one cycle after run is sampled
    run = 1'b1;
    tick();
    chk("t1_state", state, S_RUN);
    chk("t1_out_e0", out_clk, 0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("t1_out", out_clk, 32'(i % 2));
      chk("t1_en", clk_en, 32'(i % 2));
    end

    // 2: switch to SEL=3 while running; applies at the next fall
    load_sel(5'd3);
    chk("t2_pend_set", sel_pend, 1);
    chk("t2_cur_old", cur_sel, 0);
    chk("t2_out_hi", out_clk, 1);
    tick();
    chk("t2_pend_clr", sel_pend, 0);
    chk("t2_cur_new", cur_sel, 3);
    chk("t2_out_lo", out_clk, 0);
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk("t2_out", out_clk, 32'((k / 8) % 2));
      chk("t2_en", clk_en, 32'(k % 16 == 8));
    end

    // 3: SEL=2, drop run in the 2nd cycle of a high phase
    load_sel(5'd2);
    budget = 40;
    while (sel_pend && budget > 0) begin tick(); budget--; end
    chk("t3_pend_wait", sel_pend, 0);
    chk("t3_cur", cur_sel, 2);
    chk("t3_out_bnd", out_clk, 0);
    for (int k = 1; k <= 4; k++) tick();
    chk("t3_rise", out_clk, 1);
    chk("t3_rise_en", clk_en, 1);
    tick();
    chk("t3_hi2", out_clk, 1);
    run = 1'b0;
    tick();
    chk("t3_drain", state, S_DRAIN);
    chk("t3_hi3", out_clk, 1);
    chk("t3_en3", clk_en, 0);
    tick();
    chk("t3_hi4", out_clk, 1);
    chk("t3_en4", clk_en, 0);
    tick();
    chk("t3_fall", out_clk, 0);
    chk("t3_halt", state, S_HALT);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("t3_idle_out", out_clk, 0);
      chk("t3_idle_en", clk_en, 0);
      chk("t3_idle_st", state, S_HALT);
    end

    // 4: single step at SEL=1, second step during STEP ignored
    load_sel(5'd1);
    chk("t4_cur", cur_sel, 1);
    chk("t4_pend", sel_pend, 0);
    step = 1'b1;
    tick();
    chk("t4_state", state, S_STEP);
    chk("t4_out0", out_clk, 0);
    tick();
    step = 1'b0;
    chk("t4_out1", out_clk, 0);
    chk("t4_st1", state, S_STEP);
    tick();
    chk("t4_rise", out_clk, 1);
    chk("t4_en", clk_en, 1);
    tick();
    chk("t4_hi2", out_clk, 1);
    chk("t4_en_off", clk_en, 0);
    tick();
    chk("t4_fall", out_clk, 0);
    chk("t4_halt", state, S_HALT);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t4_idle_en", clk_en, 0);
      chk("t4_idle_st", state, S_HALT);
    end

    // 5: clamp, then async reset in the middle of a high phase
    load_sel(5'd24);
    chk("t5_sel24", cur_sel, 24);
    load_sel(5'd1);
    load_sel(5'd25);
    chk("t5_sel25", cur_sel, 24);
    load_sel(5'd31);
    chk("t5_sel31", cur_sel, 24);
    load_sel(5'd2);
    run = 1'b1;
    tick();
    chk("t5_run", state, S_RUN);
    for (int k = 0; k < 4; k++) tick();
    chk("t5_rise", out_clk, 1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_ar_out", out_clk, 0);
    chk("t5_ar_en", clk_en, 0);
    chk("t5_ar_st", state, S_HALT);
    chk("t5_ar_sel", cur_sel, 0);
    tick();
    run = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("t5_post_st", state, S_HALT);

    // 6: run and step together, then load collision on a boundary edge
    run = 1'b1; step = 1'b1;
    tick();
    step = 1'b0;
    chk("t6_state", state, S_RUN);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("t6_en", clk_en, 32'(i % 2));
      chk("t6_st", state, S_RUN);
    end
    load_sel(5'd1);
    chk("t6_pend1", sel_pend, 1);
    load_sel(5'd2);
    chk("t6_coll_cur", cur_sel, 1);
    chk("t6_coll_pend", sel_pend, 1);
    chk("t6_coll_out", out_clk, 0);
    tick(); tick();
    chk("t6_s1_rise", out_clk, 1);
    chk("t6_s1_en", clk_en, 1);
    tick(); tick();
    chk("t6_s1_fall", out_clk, 0);
    chk("t6_cur2", cur_sel, 2);
    chk("t6_pend0", sel_pend, 0);
    run = 1'b0;
    budget = 16;
    while (state != S_HALT && budget > 0) begin tick(); budget--; end
    chk("t6_halt", state, S_HALT);
    chk("t6_halt_out", out_clk, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
